cve2_mem_arbiter: RTL
=====================

# cve2_mem_arbiter

Two-to-one OBI arbiter that merges the core's instruction-fetch and load/store interfaces onto a single memory bus port. It sits between `cve2_core` and single-port system memory, for integrations that expose one bus master. The block arbitrates address phases and holds an in-flight request stable until it is granted. It records the source of every granted transaction and routes each in-order response back to its originator.

## Interface
Parameters:
- `MaxOutstanding`, default 2: number of granted-but-unanswered transactions tracked. Legal values are 1 to 8.

Ports (name, direction, width, meaning):
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `instr_req_i`, in, 1: fetch request.
- `instr_addr_i`, in, 32: fetch address.
- `instr_gnt_o`, out, 1: fetch grant.
- `instr_rvalid_o`, out, 1: fetch response valid.
- `instr_rdata_o`, out, 32: fetch response data.
- `instr_err_o`, out, 1: fetch response error.
- `data_req_i`, in, 1: load/store request.
- `data_we_i`, in, 1: write enable.
- `data_be_i`, in, 4: byte enables.
- `data_addr_i`, in, 32: load/store address.
- `data_wdata_i`, in, 32: write data.
- `data_gnt_o`, out, 1: load/store grant.
- `data_rvalid_o`, out, 1: load/store response valid.
- `data_rdata_o`, out, 32: load/store response data.
- `data_err_o`, out, 1: load/store response error.
- `bus_req_o`, out, 1: bus request.
- `bus_we_o`, out, 1: bus write enable.
- `bus_be_o`, out, 4: bus byte enables.
- `bus_addr_o`, out, 32: bus address.
- `bus_wdata_o`, out, 32: bus write data.
- `bus_gnt_i`, in, 1: bus grant.
- `bus_rvalid_i`, in, 1: bus response valid.
- `bus_rdata_i`, in, 32: bus response data.
- `bus_err_i`, in, 1: bus response error.
- `busy_o`, out, 1: high while the arbiter holds an outstanding transaction or a locked request.

## Operation
- **Handshake.** A transfer is accepted in a cycle where req and gnt are both high (OBI). Responses return in order, one `bus_rvalid_i` per accepted transfer.
- **Selection.** When the arbiter is not locked and both sources request, `data` wins (fixed priority).
- **Instruction-source payload.** When `instr` is selected, the bus carries `bus_we_o=0`, `bus_be_o=4'hF`, `bus_wdata_o=0`.
- **Lock.** If `bus_req_o=1` and `bus_gnt_i=0`, the arbiter registers the selected source (`lock_q`, `lock_src_q`). Selection then stays on that source until it is granted. The requester is required to hold its request stable, so no re-arbitration happens mid-handshake.
- **Grant routing.** `bus_gnt_i` is forwarded only to the selected source. The other source sees gnt=0.
- **Request gating.** `bus_req_o` = (selected req) AND NOT `fifo_full`.
- **Full FIFO.** While the FIFO is full, no new request is issued, even when a pop occurs in the same cycle. A lock already held stays held; the locked request is re-issued once an entry frees.
- **Source FIFO.** On each grant, the source ID is pushed into the FIFO, depth `MaxOutstanding`.
- **Response routing.** On `bus_rvalid_i`, the FIFO head is popped and `rvalid` is raised on that source only.
- **Response data.** `rdata` and `err` are driven to both sources unconditionally.
- **Simultaneous events.**
  - Push and pop in the same cycle: FIFO count is unchanged.
  - Grant while the FIFO is empty, with a response in the same cycle: the push happens and the response is ignored.
  - `bus_rvalid_i` while the FIFO is empty: the response is dropped, and an assertion fires.
- **Reset** (asynchronous, usable mid-transaction): FIFO emptied, lock cleared, round-robin pointer set to "data preferred". In-flight responses arriving after reset are dropped.

## Timing
- Address and response paths are combinational: zero added cycles.
- `bus_req_o` depends only on the request inputs and registered state. It never depends on `bus_gnt_i`.
- Reset values of outputs (while `rst_ni=0`):
  - `bus_req_o` = 0.
  - Both `gnt` outputs = 0.
  - Both `rvalid` outputs = 0.
  - `busy_o` = 0.
  - Payload outputs follow the selected inputs.
- Throughput: one grant per cycle when `bus_gnt_i` is held high and the FIFO is not full.

## Configuration
- **`CVE2_ARB_ROUND_ROBIN_EN` defined:** on contention with no lock, the source not granted last wins. The last-granted pointer updates on every grant.
- **`CVE2_ARB_ROUND_ROBIN_EN` undefined:** fixed data-over-instr priority, and no pointer flop exists.

## Structure
- Shared package `cve2_pkg` gets `arb_src_e` (`ArbSrcInstr=1'b0`, `ArbSrcData=1'b1`).
- One sub-module, `cve2_arb_src_fifo`: parameterised depth, 1-bit payload, exposes full/empty flags. Read and write pointers wrap modulo depth, and a count register sized `$clog2(MaxOutstanding+1)`.

## Test plan
- **Single fetch:** `instr_req_i=1`, `addr=0x80`, `bus_gnt_i=1` → `instr_gnt_o=1` the same cycle, `bus_be_o=0xF`. Next cycle `bus_rvalid_i` with `rdata=0x13` → `instr_rvalid_o=1`, `instr_rdata_o=0x13`, `data_rvalid_o=0`.
- **Contention, fixed priority:** both requests for 4 cycles with `gnt=1` → data granted all 4 cycles. With `CVE2_ARB_ROUND_ROBIN_EN` → D, I, D, I.
- **Lock:** `data_req_i` with `gnt=0` for 3 cycles, `instr_req_i` raised in cycle 2 → bus stays on data until `gnt`; instr granted in the following cycle.
- **Full FIFO:** `MaxOutstanding=2`, two grants, no responses → `bus_req_o=0` despite a pending request. First `rvalid` → request re-issued the next cycle.
- **Interleaved responses:** sequence I, D, I granted, three `rvalid` → routed instr, data, instr, in order.
- **Mid-transaction reset:** reset with 2 outstanding, then a stray `bus_rvalid_i` → no `rvalid` output and `busy_o=0`.

Source files
------------

// File: rtl/cve2_pkg.sv
// Shared core package: types common to the bus-side blocks.
package cve2_pkg;

  typedef enum logic {
    ArbSrcInstr = 1'b0,
    ArbSrcData  = 1'b1
  } arb_src_e;

endpackage

// File: rtl/cve2_arb_src_fifo.sv
// Small FIFO of arbiter source IDs, one entry per granted-but-unanswered bus transfer.
module cve2_arb_src_fifo
  import cve2_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     push_i,
  input  arb_src_e wdata_i,
  input  logic     pop_i,
  output arb_src_e rdata_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

  arb_src_e        mem_q [Depth];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign full_o  = (count_q == FullCnt);
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rptr_q];

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) wptr_q <= (wptr_q == LastPtr) ? '0 : wptr_q + PtrW'(1);
      if (do_pop)  rptr_q <= (rptr_q == LastPtr) ? '0 : rptr_q + PtrW'(1);
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/cve2_mem_arbiter.sv
// Two-to-one OBI arbiter merging instruction fetch and load/store onto one bus port.
// Define CVE2_ARB_ROUND_ROBIN_EN for round-robin on contention instead of data-first priority.
module cve2_mem_arbiter
  import cve2_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_err_i,
  output logic        busy_o
);

  arb_src_e sel_src, prio_src, lock_src_q, fifo_head;
  logic     lock_q, sel_req, bus_grant, fifo_full, fifo_empty, fifo_pop;

`ifdef CVE2_ARB_ROUND_ROBIN_EN
  arb_src_e last_q;

  assign prio_src = (last_q == ArbSrcData) ? ArbSrcInstr : ArbSrcData;

  // Reset to "instr granted last" so data is preferred first.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)        last_q <= ArbSrcInstr;
    else if (bus_grant) last_q <= sel_src;
  end
`else
  assign prio_src = ArbSrcData;
`endif

  always_comb begin
    sel_src = ArbSrcInstr;
    if (lock_q)                         sel_src = lock_src_q;
    else if (data_req_i && instr_req_i) sel_src = prio_src;
    else if (data_req_i)                sel_src = ArbSrcData;
  end

  always_comb begin
    sel_req     = instr_req_i;
    bus_we_o    = 1'b0;
    bus_be_o    = 4'hF;
    bus_addr_o  = instr_addr_i;
    bus_wdata_o = '0;
    if (sel_src == ArbSrcData) begin
      sel_req     = data_req_i;
      bus_we_o    = data_we_i;
      bus_be_o    = data_be_i;
      bus_addr_o  = data_addr_i;
      bus_wdata_o = data_wdata_i;
    end
  end

  // Qualified by rst_ni so handshake outputs stay quiet while reset is held.
  assign bus_req_o   = rst_ni & sel_req & ~fifo_full;
  assign bus_grant   = bus_req_o & bus_gnt_i;
  assign instr_gnt_o = bus_grant & (sel_src == ArbSrcInstr);
  assign data_gnt_o  = bus_grant & (sel_src == ArbSrcData);

  assign fifo_pop       = rst_ni & bus_rvalid_i & ~fifo_empty;
  assign instr_rvalid_o = fifo_pop & (fifo_head == ArbSrcInstr);
  assign data_rvalid_o  = fifo_pop & (fifo_head == ArbSrcData);
  assign instr_rdata_o  = bus_rdata_i;
  assign data_rdata_o   = bus_rdata_i;
  assign instr_err_o    = bus_err_i;
  assign data_err_o     = bus_err_i;

  assign busy_o = lock_q | ~fifo_empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q     <= 1'b0;
      lock_src_q <= ArbSrcInstr;
    end else if (bus_grant) begin
      lock_q <= 1'b0;
    end else if (bus_req_o) begin
      lock_q     <= 1'b1;
      lock_src_q <= sel_src;
    end
  end

  cve2_arb_src_fifo #(
    .Depth (MaxOutstanding)
  ) u_src_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (bus_grant),
    .wdata_i (sel_src),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  rvalid_without_outstanding_a : assert property (
    @(posedge clk_i) disable iff (!rst_ni) bus_rvalid_i |-> !fifo_empty
  );

endmodule
